// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling of a synchronized rxd line, one-cycle
// valid/frame_err strobes, and break hold-off so a held-low line cannot retrigger.
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | timing to start-bit mid-point, rejecting glitches
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling stop bit; strobe valid or frame_err
//   BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [13:0] CNT_BIT_END  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] CNT_HALF_END = 14'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]  state;
  logic        rx_meta;
  logic        rx_s;
  logic [13:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (clk_cnt == CNT_HALF_END) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 14'd1;
          end
        end
        S_DATA: begin
          if (clk_cnt == CNT_BIT_END) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_cnt == 3'd7) state <= S_STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 14'd1;
          end
        end
        S_STOP: begin
          if (clk_cnt == CNT_BIT_END) begin
            clk_cnt <= '0;
            if (rx_s) begin
              data  <= shift_reg;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 14'd1;
          end
        end
        S_BREAK: begin
          clk_cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          clk_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with a shortened bit period (100 clocks/bit)
// so the whole run stays small; expected bytes are queued as frames are driven.
module tb_uart_rx;

  localparam int CPB  = 100;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0;
  int n_err   = 0;
  int t_fall  = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] exp_q[$];
  int         vcyc_q[$];

  uart_rx #(.CLK_FREQ(960000), .BAUD(9600)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset && (valid || frame_err)) begin
      chk("valid_err_exclusive", 32'(valid & frame_err), 0);
      chk("pulse_width", 32'(prev_pulse), 0);
    end
    if (!reset && valid) begin
      n_valid++;
      vcyc_q.push_back(cyc);
      chk("busy_in_valid", 32'(busy), 0);
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("data", 32'(data), 32'(exp_q.pop_front()));
    end
    if (!reset && frame_err) n_err++;
    prev_pulse = valid | frame_err;
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int cpb, input logic stop, input logic expect_ok);
    if (expect_ok) exp_q.push_back(b);
    t_fall = cyc;
    rxd = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (cpb) @(negedge clk);
    end
    rxd = stop;
    repeat (cpb) @(negedge clk);
  endtask

  initial begin
    int v0, e0, gap;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_data", 32'(data), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_busy", 32'(busy), 0);
    idle(20);

    // 0x55 with latency check: 2 sync flops + IDLE detect edge + HALF + 9 bits
    send(8'h55, CPB, 1'b1, 1'b1);
    idle(CPB);
    chk("latency_55", 32'(vcyc_q.size() > 0 ? vcyc_q[vcyc_q.size()-1] - t_fall : -1),
        32'(HALF + 9*CPB + 3));
    chk("no_err_55", 32'(n_err), 0);

    // back-to-back frames, zero idle between stop and next start
    vcyc_q.delete();
    send(8'hA3, CPB, 1'b1, 1'b1);
    send(8'h00, CPB, 1'b1, 1'b1);
    idle(CPB);
    chk("b2b_count", 32'(vcyc_q.size()), 2);
    gap = (vcyc_q.size() == 2) ? vcyc_q[1] - vcyc_q[0] : -1;
    chk("b2b_spacing", 32'(gap), 32'(10*CPB));

    // short low glitch: start-bit check rejects it
    v0 = n_valid; e0 = n_err;
    rxd = 1'b0;
    repeat (29) @(negedge clk);
    rxd = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 1);
    repeat (HALF - 29 + 5) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 0);
    idle(CPB);
    chk("glitch_no_valid", 32'(n_valid - v0), 0);
    chk("glitch_no_err", 32'(n_err - e0), 0);
    chk("glitch_data", 32'(data), 32'h00);

    // bad stop bit, then line held low (break)
    v0 = n_valid; e0 = n_err;
    send(8'h3C, CPB, 1'b0, 1'b0);
    repeat (2*CPB) @(negedge clk);
    chk("break_err_once", 32'(n_err - e0), 1);
    chk("break_busy_held", 32'(busy), 1);
    chk("break_data_kept", 32'(data), 32'h00);
    idle(10);
    chk("break_released", 32'(busy), 0);
    chk("break_no_valid", 32'(n_valid - v0), 0);
    idle(CPB);
    send(8'h7E, CPB, 1'b1, 1'b1);
    idle(CPB);
    chk("after_break_data", 32'(data), 32'h7E);

    // reset mid-DATA of 0xFF aborts with no pulse
    v0 = n_valid; e0 = n_err;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3*CPB) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_data_cleared", 32'(data), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (7*CPB) @(negedge clk);
    chk("abort_no_pulse", 32'((n_valid - v0) + (n_err - e0)), 0);
    send(8'h81, CPB, 1'b1, 1'b1);
    idle(CPB);
    chk("after_abort_data", 32'(data), 32'h81);

    // +/-2% bit-period error
    send(8'hC9, CPB - 2, 1'b1, 1'b1);
    idle(CPB);
    chk("slow_fast_c9_a", 32'(data), 32'hC9);
    idle(CPB);
    send(8'h00, CPB, 1'b1, 1'b1);
    idle(CPB);
    send(8'hC9, CPB + 2, 1'b1, 1'b1);
    idle(CPB);
    chk("slow_fast_c9_b", 32'(data), 32'hC9);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("total_errs", 32'(n_err), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
